// File: rtl/data_mem_copy_engine.sv
// Copies len 32-bit words from src_addr to dst_addr over the data memory port, one READ and one WRITE cycle per word.
// Latency 2*len+1 cycles from accept to done; start is ignored while not in IDLE, and memory is assumed always ready.
module data_mem_copy_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData,
    output logic              MemRead,
    output logic              MemWrite
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   src_ptr;
    logic [ADDR_W-1:0]   dst_ptr;
    logic [LEN_W-1:0]    len_r;
    logic [DATA_W-1:0]   buffer;
    logic [LEN_W-1:0]    wd_next;
    logic [ADDR_W-1:0]   src_next;
    logic [ADDR_W-1:0]   dst_next;

    assign wd_next  = words_done + LEN_W'(1);
    assign src_next = src_ptr + ADDR_W'(4);
    assign dst_next = dst_ptr + ADDR_W'(4);

    // Outputs are registered and loaded on entry to each state so they always match the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            len_r      <= '0;
            buffer     <= '0;
            words_done <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            address    <= '0;
            writeData  <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_READ;
                            src_ptr    <= src_addr;
                            dst_ptr    <= dst_addr;
                            len_r      <= len;
                            words_done <= '0;
                            busy       <= 1'b1;
                            MemRead    <= 1'b1;
                            address    <= src_addr;
                        end
                    end
                end
                S_READ: begin
                    state     <= S_WRITE;
                    buffer    <= readData;
                    writeData <= readData;
                    MemRead   <= 1'b0;
                    MemWrite  <= 1'b1;
                    address   <= dst_ptr;
                end
                S_WRITE: begin
                    src_ptr    <= src_next;
                    dst_ptr    <= dst_next;
                    words_done <= wd_next;
                    MemWrite   <= 1'b0;
                    writeData  <= '0;
                    if (wd_next == len_r) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        address <= '0;
                    end else begin
                        state   <= S_READ;
                        MemRead <= 1'b1;
                        address <= src_next;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                S_ERR: begin
                    state <= S_IDLE;
                    err   <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    address   <= '0;
                    writeData <= '0;
                    MemRead   <= 1'b0;
                    MemWrite  <= 1'b0;
                end
            endcase
        end
    end

endmodule
